// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: stores header/payload/parity bytes with a header tag bit.
// Latency: data_out is registered, valid one cycle after an accepted read; flags are combinational.
// Backpressure: full/empty flags; a write when full or a read when empty is silently dropped.
//
// Ports:
//   clk, rst (async active-low), soft_rst (sync active-high flush)
//   write_enb/lfd_state/data_in : write side; lfd_state tags header bytes
//   read_enb/data_out           : read side; data_out blanks to 0 once the packet's parity byte is out
//   full, empty                 : occupancy flags from the pre-edge pointers
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  // MSB of each stored word marks a packet header byte.
  logic [WIDTH:0] mem [DEPTH];

  // Extra wrap bit distinguishes full from empty when the low bits match.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  // Bytes still to be read in the current packet (payload + parity).
  logic [6:0]     pkt_cnt;

  logic           wr_acc;
  logic           rd_acc;
  logic [WIDTH:0] rd_word;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign wr_acc  = write_enb && !full;
  assign rd_acc  = read_enb && !empty;
  assign rd_word = mem[rd_ptr[PTR_W-1:0]];

  // Storage has no reset; a flush only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (wr_acc && !soft_rst) begin
      mem[wr_ptr[PTR_W-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else if (soft_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= rd_word[WIDTH-1:0];
        if (rd_word[WIDTH]) begin
          // Header: length field sits above the 2-bit address; +1 for the parity byte.
          pkt_cnt <= 7'(rd_word[WIDTH-1:2]) + 7'd1;
        end else if (pkt_cnt != 7'd0) begin
          pkt_cnt <= pkt_cnt - 7'd1;
        end
      end else if (pkt_cnt == 7'd0) begin
        // Packet fully delivered: blank the output bus.
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

  logic       clk;
  logic       rst;
  logic       soft_rst;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int tests;
  int fails;

  router_fifo #(.WIDTH(8), .DEPTH(16), .PTR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .soft_rst  (soft_rst),
    .write_enb (write_enb),
    .read_enb  (read_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       re;
    logic       lfd;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then sample 1ns later.
  task automatic step(input logic we, input logic re, input logic lfd,
                      input logic sr, input logic [7:0] din);
    write_enb = we;
    read_enb  = re;
    lfd_state = lfd;
    soft_rst  = sr;
    data_in   = din;
    @(posedge clk);
    #1;
    write_enb = 1'b0;
    read_enb  = 1'b0;
    lfd_state = 1'b0;
    soft_rst  = 1'b0;
    data_in   = 8'h00;
  endtask

  vec_t vecs[15];
  logic [7:0] model_q[$];
  logic [7:0] exp_b;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0; soft_rst = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;

    // Packet pass-through, then a zero-length packet (hold while pkt_cnt != 0).
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h0E, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h44, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h55, 8'h03, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h55, 1'b0, 1'b1};

    // ---- Reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_dout", 32'(data_out), 32'd0);
    rst = 1'b1;

    // ---- Async reset mid-cycle with live data ----
    step(1, 0, 1, 0, 8'h0E);
    step(0, 1, 0, 0, 8'h00);
    chk("ar_pre_dout", 32'(data_out), 32'h0E);
    step(1, 0, 0, 0, 8'h99);
    chk("ar_pre_empty", 32'(empty), 32'd0);
    #3 rst = 1'b0;
    #1;
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_full", 32'(full), 32'd0);
    chk("ar_dout", 32'(data_out), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 8'h5C);
    chk("ar_write_empty", 32'(empty), 32'd0);
    step(0, 1, 0, 0, 8'h00);
    chk("ar_write_dout", 32'(data_out), 32'h5C);
    step(0, 0, 0, 0, 8'h00);
    chk("ar_drain_empty", 32'(empty), 32'd1);

    // ---- Table vectors ----
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].we, vecs[i].re, vecs[i].lfd, 1'b0, vecs[i].din);
      chk($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
    end
    step(0, 0, 0, 0, 8'h00);
    chk("vec_blank_dout", 32'(data_out), 32'd0);

    // ---- Full boundary ----
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0, 8'hA0 + 8'(i));
      chk($sformatf("fill%0d_full", i), 32'(full), (i == 15) ? 32'd1 : 32'd0);
    end
    step(1, 0, 0, 0, 8'hFF);
    chk("over_write_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 8'h00);
      chk($sformatf("drain%0d_dout", i), 32'(data_out), 32'hA0 + 32'(i));
      chk($sformatf("drain%0d_full", i), 32'(full), 32'd0);
      chk($sformatf("drain%0d_empty", i), 32'(empty), (i == 15) ? 32'd1 : 32'd0);
    end
    step(0, 1, 0, 0, 8'h00);
    chk("empty_read_dout", 32'(data_out), 32'd0);

    // ---- Simultaneous read+write at occupancy 5 ----
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'hB0 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, 8'hB5 + 8'(i));
      chk($sformatf("rw5_%0d_dout", i), 32'(data_out), 32'hB0 + 32'(i));
      chk($sformatf("rw5_%0d_flags", i), {30'd0, full, empty}, 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 8'h00);
      chk($sformatf("rw5_drain%0d", i), 32'(data_out), 32'hB5 + 32'(i));
    end
    chk("rw5_empty", 32'(empty), 32'd1);

    // ---- Simultaneous read+write when full ----
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'hC0 + 8'(i));
    chk("rwf_full", 32'(full), 32'd1);
    step(1, 1, 0, 0, 8'hEE);
    chk("rwf_dout", 32'(data_out), 32'hC0);
    chk("rwf_full_after", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step(0, 1, 0, 0, 8'h00);
      chk($sformatf("rwf_drain%0d", i), 32'(data_out), 32'hC0 + 32'(i));
      chk($sformatf("rwf_empty%0d", i), 32'(empty), (i == 15) ? 32'd1 : 32'd0);
    end

    // ---- Wrap-around streaming, 40 bytes at occupancy 2 ----
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'(i * 7 + 3);
      if (i < 2) begin
        step(1, 0, 0, 0, b);
      end else begin
        step(1, 1, 0, 0, b);
        exp_b = model_q.pop_front();
        chk($sformatf("wrap%0d_dout", i), 32'(data_out), 32'(exp_b));
      end
      model_q.push_back(b);
      chk($sformatf("wrap%0d_flags", i), {30'd0, full, empty}, 32'd0);
    end
    while (model_q.size() > 0) begin
      step(0, 1, 0, 0, 8'h00);
      exp_b = model_q.pop_front();
      chk("wrap_tail_dout", 32'(data_out), 32'(exp_b));
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // ---- Soft reset with 6 stored ----
    step(1, 0, 1, 0, 8'h0E);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 8'hD0 + 8'(i));
    step(0, 1, 0, 0, 8'h00);
    chk("sr_pre_dout", 32'(data_out), 32'h0E);
    chk("sr_pre_empty", 32'(empty), 32'd0);
    step(1, 0, 0, 1, 8'h77);
    chk("sr_empty", 32'(empty), 32'd1);
    chk("sr_full", 32'(full), 32'd0);
    chk("sr_dout", 32'(data_out), 32'd0);
    step(1, 0, 0, 0, 8'h5A);
    chk("sr_new_empty", 32'(empty), 32'd0);
    step(0, 1, 0, 0, 8'h00);
    chk("sr_new_dout", 32'(data_out), 32'h5A);
    chk("sr_new_drained", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
